// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
// Each bit is held for the latched Prescale count (0 treated as 1); TX_OUT and Busy are registered.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VLD,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              pcnt_q, pcnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [5:0]              p_q, p_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    bit_end;

    assign bit_end = (pcnt_q == (p_q - 6'd1));

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        p_d       = p_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        if (state_q != IDLE) begin
            pcnt_d = bit_end ? 6'd0 : (pcnt_q + 6'd1);
        end

        case (state_q)
            IDLE: begin
                pcnt_d    = '0;
                bit_cnt_d = '0;
                if (DATA_VLD) begin
                    state_d   = START;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    // Parity is resolved at acceptance, so PAR_TYP need not be kept on its own
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    p_d       = (Prescale == 6'd0) ? 6'd1 : Prescale;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so the line changes with the state
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_q       <= 6'd1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
